// File: rtl/writeback_ctrl.sv
// Writeback controller: merges a no-backpressure ALU result path with a
// queued load-return path onto two register-file write ports.
module writeback_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        wb_alu_en,
  output logic [4:0]  address_alu,
  output logic [31:0] write_data_alu,
  output logic        wb_mem_en,
  output logic [4:0]  address_mem,
  output logic [31:0] write_data_mem,
  output logic [31:0] pending_mask,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              wb_alu_en_q, wb_alu_en_d;
  logic [RD_W-1:0]   address_alu_q, address_alu_d;
  logic [DATA_W-1:0] write_data_alu_q, write_data_alu_d;
  logic              wb_mem_en_q, wb_mem_en_d;
  logic [RD_W-1:0]   address_mem_q, address_mem_d;
  logic [DATA_W-1:0] write_data_mem_q, write_data_mem_d;

  logic   full_c, push_c, pop_c, collide_c;
  entry_t head_c;

  // Handshake, pop and collision decode
  always_comb begin
    full_c    = (count_q == CNT_W'(DEPTH));
    push_c    = mem_valid && !full_c && (mem_rd != '0);
    pop_c     = (count_q != '0);
    head_c    = fifo_q[rd_ptr_q];
    collide_c = pop_c && alu_valid && (alu_rd != '0) && (alu_rd == head_c.rd);
  end

  assign mem_ready = !full_c;

  // Next-state for pointers, occupancy, drop counter and write ports
  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    drop_cnt_d       = drop_cnt_q;
    wb_alu_en_d      = 1'b0;
    address_alu_d    = '0;
    write_data_alu_d = '0;
    wb_mem_en_d      = 1'b0;
    address_mem_d    = '0;
    write_data_mem_d = '0;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (alu_valid && (alu_rd != '0)) begin
      wb_alu_en_d      = 1'b1;
      address_alu_d    = alu_rd;
      write_data_alu_d = alu_data;
    end

    // The ALU result is newer than a queued load to the same register
    if (collide_c) begin
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (pop_c) begin
      wb_mem_en_d      = 1'b1;
      address_mem_d    = head_c.rd;
      write_data_mem_d = head_c.data;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      drop_cnt_q       <= '0;
      wb_alu_en_q      <= 1'b0;
      address_alu_q    <= '0;
      write_data_alu_q <= '0;
      wb_mem_en_q      <= 1'b0;
      address_mem_q    <= '0;
      write_data_mem_q <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      drop_cnt_q       <= drop_cnt_d;
      wb_alu_en_q      <= wb_alu_en_d;
      address_alu_q    <= address_alu_d;
      write_data_alu_q <= write_data_alu_d;
      wb_mem_en_q      <= wb_mem_en_d;
      address_mem_q    <= address_mem_d;
      write_data_mem_q <= write_data_mem_d;
    end
  end

  // Entry storage; validity is tracked by pointers/count, so no reset needed
  always_ff @(posedge clk) begin
    if (rst_n && push_c) begin
      fifo_q[wr_ptr_q] <= '{rd: mem_rd, data: mem_data};
    end
  end

  // Registers with a load still queued
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx          = '0;
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) pending_mask[fifo_q[idx].rd] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  assign wb_alu_en      = wb_alu_en_q;
  assign address_alu    = address_alu_q;
  assign write_data_alu = write_data_alu_q;
  assign wb_mem_en      = wb_mem_en_q;
  assign address_mem    = address_mem_q;
  assign write_data_mem = write_data_mem_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed, table-driven bench for writeback_ctrl (DEPTH=4).
module tb_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_alu_en;
  logic [4:0]  address_alu;
  logic [31:0] write_data_alu;
  logic        wb_mem_en;
  logic [4:0]  address_mem;
  logic [31:0] write_data_mem;
  logic [31:0] pending_mask;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  writeback_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_alu_en(wb_alu_en), .address_alu(address_alu), .write_data_alu(write_data_alu),
    .wb_mem_en(wb_mem_en), .address_mem(address_mem), .write_data_mem(write_data_mem),
    .pending_mask(pending_mask), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        ea;
    logic [4:0]  eaa;
    logic [31:0] ead;
    logic        em;
    logic [4:0]  ema;
    logic [31:0] emd;
    logic [31:0] epm;
    logic [7:0]  edc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic av, logic [4:0] ard, logic [31:0] adat,
                              logic mv, logic [4:0] mrd, logic [31:0] mdat,
                              logic ea, logic [4:0] eaa, logic [31:0] ead,
                              logic em, logic [4:0] ema, logic [31:0] emd,
                              logic [31:0] epm, logic [7:0] edc);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.ea = ea; v.eaa = eaa; v.ead = ead;
    v.em = em; v.ema = ema; v.emd = emd;
    v.epm = epm; v.edc = edc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                       input logic [31:0] adat, input logic mv, input logic [4:0] mrd,
                       input logic [31:0] mdat);
    @(negedge clk);
    rst_n = rst; alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, "_alu"}, 64'({wb_alu_en, address_alu, write_data_alu}), 64'({v.ea, v.eaa, v.ead}));
    check({tag, "_mem"}, 64'({wb_mem_en, address_mem, write_data_mem}), 64'({v.em, v.ema, v.emd}));
    check({tag, "_pend"}, 64'(pending_mask), 64'(v.epm));
    check({tag, "_drop"}, 64'(drop_cnt), 64'(v.edc));
    check({tag, "_ready"}, 64'(mem_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;

    // rst av ard adat | mv mrd mdat | ea eaa ead | em ema emd | pend drop
    vecs.push_back(mk(0, 0, 0, 0,        0, 0, 0,            0, 0, 0,        0, 0, 0,            32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        0, 0, 0,            32'h0, 0));
    // ALU only
    vecs.push_back(mk(1, 1, 5, 32'h1234, 0, 0, 0,            1, 5, 32'h1234, 0, 0, 0,            32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        0, 0, 0,            32'h0, 0));
    // Load latency
    vecs.push_back(mk(1, 0, 0, 0,        1, 7, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0,            32'h80, 0));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        1, 7, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        0, 0, 0,            32'h0, 0));
    // Collision
    vecs.push_back(mk(1, 0, 0, 0,        1, 9, 32'hAAAA,     0, 0, 0,        0, 0, 0,            32'h200, 0));
    vecs.push_back(mk(1, 1, 9, 32'h55,   0, 0, 0,            1, 9, 32'h55,   0, 0, 0,            32'h0, 1));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        0, 0, 0,            32'h0, 1));
    // Both ports same cycle, different registers
    vecs.push_back(mk(1, 0, 0, 0,        1, 3, 32'h33,       0, 0, 0,        0, 0, 0,            32'h8, 1));
    vecs.push_back(mk(1, 1, 4, 32'h44,   1, 6, 32'h66,       1, 4, 32'h44,   1, 3, 32'h33,       32'h40, 1));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        1, 6, 32'h66,       32'h0, 1));
    // ALU to x0 is not written
    vecs.push_back(mk(1, 1, 0, 32'h99,   0, 0, 0,            0, 0, 0,        0, 0, 0,            32'h0, 1));
    // Load to x0 accepted, not stored
    vecs.push_back(mk(1, 0, 0, 0,        1, 0, 32'h77,       0, 0, 0,        0, 0, 0,            32'h0, 1));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        0, 0, 0,            32'h0, 1));
    // Six back-to-back loads: one pop per push, never full
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mk(1, 0, 0, 0, 1, 5'(10 + k), 32'(16 + k), 0, 0, 0,
                        (k != 0), (k != 0) ? 5'(9 + k) : 5'd0, (k != 0) ? 32'(15 + k) : 32'd0,
                        32'h1 << (10 + k), 1));
    end
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        1, 15, 32'd21,      32'h0, 1));
    // Reset mid-operation discards the queue
    vecs.push_back(mk(1, 0, 0, 0,        1, 20, 32'h20,      0, 0, 0,        0, 0, 0,            32'h0010_0000, 1));
    vecs.push_back(mk(1, 0, 0, 0,        1, 21, 32'h21,      0, 0, 0,        1, 20, 32'h20,      32'h0020_0000, 1));
    vecs.push_back(mk(0, 1, 2, 32'h22,   1, 22, 32'h22,      0, 0, 0,        0, 0, 0,            32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        0, 0, 0,            32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0,        1, 8, 32'h88,       0, 0, 0,        0, 0, 0,            32'h100, 0));
    vecs.push_back(mk(1, 0, 0, 0,        0, 0, 0,            0, 0, 0,        1, 8, 32'h88,       32'h0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat,
            vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
      check_all($sformatf("v%0d", i), vecs[i]);
    end

    // Continuous collisions on register 9: drop counter saturates at 255
    for (int k = 0; k < 258; k++) begin
      drive(1'b1, 1'b1, 5'd9, 32'(256 + k), 1'b1, 5'd9, 32'(k));
      check($sformatf("sat%0d_mem_en", k), 64'(wb_mem_en), 64'(0));
      check($sformatf("sat%0d_drop", k), 64'(drop_cnt), 64'((k > 255) ? 255 : k));
      check($sformatf("sat%0d_alu", k), 64'({wb_alu_en, address_alu, write_data_alu}),
            64'({1'b1, 5'd9, 32'(256 + k)}));
    end
    // Last queued load drains once the ALU goes quiet
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("sat_drain_mem", 64'({wb_mem_en, address_mem, write_data_mem}), 64'({1'b1, 5'd9, 32'd257}));
    check("sat_drain_drop", 64'(drop_cnt), 64'(255));
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("sat_idle_mem", 64'(wb_mem_en), 64'(0));
    check("sat_idle_pend", 64'(pending_mask), 64'(0));
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("final_reset_drop", 64'(drop_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_ctrl.md
WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of load-return FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port alu_valid, input, 1, ALU result present this cycle; this path has no backpressure.
REQ-005 SHALL have port alu_rd, input, 5, ALU destination register.
REQ-006 SHALL have port alu_data, input, 32, ALU result.
REQ-007 SHALL have port mem_valid, input, 1, load-return data offered.
REQ-008 SHALL have port mem_ready, output, 1, load return accepted; equals !full, combinational from state only.
REQ-009 SHALL have port mem_rd, input, 5, load destination register.
REQ-010 SHALL have port mem_data, input, 32, load data.
REQ-011 SHALL have port wb_alu_en, output, 1, register-file ALU write port enable.
REQ-012 SHALL have ports address_alu (output, 5) and write_data_alu (output, 32), the register-file ALU write address and data.
REQ-013 SHALL have port wb_mem_en, output, 1, register-file load write port enable.
REQ-014 SHALL have ports address_mem (output, 5) and write_data_mem (output, 32), the register-file load write address and data.
REQ-015 SHALL have port pending_mask, output, 32, registers with a load queued; bit i is 1 iff any valid FIFO entry has rd == i.
REQ-016 SHALL have port drop_cnt, output, 8, saturating count of suppressed load writes.

Function
REQ-017 SHALL register every wb_* / address_* / write_data_* output; when the matching enable is 0, the address and data SHALL be 0.
REQ-018 SHALL drive the ALU outputs as follows: alu_valid=1 and alu_rd!=0 at edge N gives wb_alu_en=1 with alu_rd/alu_data after edge N (1-cycle latency); otherwise wb_alu_en=0.
REQ-019 SHALL push a load return (handshake) at an edge where mem_valid && mem_ready; mem_rd==0 SHALL be accepted but not stored.
REQ-020 SHALL be a FIFO of DEPTH entries {rd, data} with wrapping read/write pointers and an occupancy count 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-021 SHALL pop one entry per edge when non-empty; an entry pushed at edge N is earliest popped at edge N+1 (2-cycle mem_valid-to-wb_mem_en latency); the FIFO SHALL NOT bypass.
REQ-022 SHALL allow push and pop at the same edge; count is then unchanged and pointers both advance.
REQ-023 On a pop, SHALL set wb_mem_en=1 with head rd/data after that edge, unless the collision rule (REQ-024) applies.
REQ-024 Collision: SHALL treat it as popping while alu_valid=1 and alu_rd==head.rd (nonzero); the ALU result is newer and wins, so the head SHALL still be popped, wb_mem_en=0 and drop_cnt incremented (saturating at 255).
REQ-025 When alu_rd != head.rd, SHALL issue both ports in the same cycle.
REQ-026 SHALL compute pending_mask combinationally from valid FIFO entries; bit 0 SHALL always be 0.
REQ-027 SHALL keep mem_ready=0 while full; mem_valid while full SHALL be ignored, with no state change.

Reset
REQ-028 When rst_n=0 at an edge, SHALL set count=0, pointers=0, drop_cnt=0, all wb enables, addresses and data to 0, mem_ready=1 and pending_mask=0.
REQ-029 SHALL discard queued entries on reset mid-operation, with no write issued at or after the reset edge; the first accepted push after reset SHALL be stored at entry 0.

Verification
REQ-030 SHALL cover ALU-only: alu rd=5, data=0x1234 at edge 1 -> wb_alu_en=1, address_alu=5, write_data_alu=0x1234 after edge 1; 0 after edge 2 if idle.
REQ-031 SHALL cover load latency: mem rd=7, data=0xDEADBEEF at edge 1 -> pending_mask=0x80 after edge 1; wb_mem_en=1, address_mem=7 after edge 2; pending_mask=0 after edge 2.
REQ-032 SHALL cover full: 4 back-to-back pushes with ALU busy colliding every cycle is not required; hold mem_valid=1 for 6 cycles with DEPTH=4 -> mem_ready stays 1 (pop rate = push rate); force fill by reset-free burst and confirm mem_ready=0 never coincides with a stored push.
REQ-033 SHALL cover collision: queued rd=9; ALU rd=9, data=0x55 on the pop edge -> wb_alu_en=1 for register 9, wb_mem_en=0, drop_cnt=1.
REQ-034 SHALL cover x0 and reset: mem rd=0 -> accepted with mem_ready=1, no wb_mem_en and pending_mask unchanged; then queue 2 entries and assert rst_n=0 -> no wb_mem_en afterwards, drop_cnt=0.
